pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 179 +++++++++++++++++
 tb/tb_pll_reset_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL lock / reset sequencer.
//
// Synchronizes the raw PLL lock. It releases the downstream reset only after
// the lock has been stable for LOCK_WAIT_CYC cycles. If no lock arrives
// within TIMEOUT_CYC cycles, it pulses the PLL lock-detector reset. After
// MAX_RETRY retries (legal range 0..15) it parks in a terminal fault state.
//
// Ports:
//   clock_in          in   free-running reference clock
//   rst_in            in   asynchronous active-high reset
//   pll_lock_in       in   raw PLL lock, asynchronous to clock_in
//   pll_stdy_rst_out  out  PLL USR_LOCKED_STDY_RST pulse
//   sys_rst_out       out  active-high downstream reset (low only in RUN)
//   locked_out        out  high while running with lock
//   lost_out          out  sticky: lock lost while running
//   fault_out         out  sticky: retries exhausted
//   retry_cnt_out     out  retries issued (saturating)
//
// Build option: define PLL_SEQ_RELOCK_EN to restart the full lock sequence
// on lock loss in RUN. Otherwise the block stays in RUN with the reset
// released, and locked_out follows the synchronized lock.

module pll_reset_seq #(
    parameter int unsigned LOCK_WAIT_CYC = 16,
    parameter int unsigned TIMEOUT_CYC   = 100,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned RST_PULSE_CYC = 4
) (
    input  logic       clock_in,
    input  logic       rst_in,
    input  logic       pll_lock_in,
    output logic       pll_stdy_rst_out,
    output logic       sys_rst_out,
    output logic       locked_out,
    output logic       lost_out,
    output logic       fault_out,
    output logic [3:0] retry_cnt_out
);

    // One shared counter serves as lock timer, stability count and pulse width.
    localparam int unsigned MaxAb  = (LOCK_WAIT_CYC > TIMEOUT_CYC) ? LOCK_WAIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CntMax = (MaxAb > RST_PULSE_CYC) ? MaxAb : RST_PULSE_CYC;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] LockLast    = CW'(LOCK_WAIT_CYC - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] PulseLast   = CW'(RST_PULSE_CYC - 1);
    localparam logic [3:0]    RetryMax    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StWaitLock,
        StStable,
        StRetry,
        StRun,
        StFault
    } state_e;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_stdy_rst;
    logic          r_sys_rst;
    logic          r_locked;
    logic          r_lost;
    logic          r_fault;
    logic [3:0]    r_retry;
    logic          w_lock_s;

    // Two-flop synchronizer. Only w_lock_s is used downstream.
    always_ff @(posedge clock_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;

    // Outputs are registered alongside the state, so each takes its new value
    // on the same edge as the transition that causes it.
    always_ff @(posedge clock_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= StWaitLock;
            r_cnt      <= '0;
            r_stdy_rst <= 1'b0;
            r_sys_rst  <= 1'b1;
            r_locked   <= 1'b0;
            r_lost     <= 1'b0;
            r_fault    <= 1'b0;
            r_retry    <= 4'd0;
        end else begin
            unique case (r_state)
                StWaitLock: begin
                    // Lock takes priority over a timeout on the same edge.
                    if (w_lock_s) begin
                        r_state <= StStable;
                        r_cnt   <= '0;
                    end else if (r_cnt == TimeoutLast) begin
                        r_cnt <= '0;
                        if (r_retry == RetryMax) begin
                            r_state <= StFault;
                            r_fault <= 1'b1;
                        end else begin
                            r_state    <= StRetry;
                            r_stdy_rst <= 1'b1;
                            if (r_retry != 4'hF) begin
                                r_retry <= r_retry + 4'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StStable: begin
                    if (!w_lock_s) begin
                        // Lock glitch: restart the wait without using up a retry.
                        r_state <= StWaitLock;
                        r_cnt   <= '0;
                    end else if (r_cnt == LockLast) begin
                        r_state   <= StRun;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b0;
                        r_locked  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StRetry: begin
                    // Lock is ignored while the detector is held in reset.
                    if (r_cnt == PulseLast) begin
                        r_state    <= StWaitLock;
                        r_cnt      <= '0;
                        r_stdy_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StRun: begin
`ifdef PLL_SEQ_RELOCK_EN
                    if (!w_lock_s) begin
                        r_state   <= StWaitLock;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b1;
                        r_locked  <= 1'b0;
                        r_lost    <= 1'b1;
                        r_retry   <= 4'd0;
                    end
`else
                    r_locked <= w_lock_s;
                    if (!w_lock_s) begin
                        r_lost <= 1'b1;
                    end
`endif
                end
                StFault: begin
                    r_sys_rst  <= 1'b1;
                    r_stdy_rst <= 1'b0;
                    r_fault    <= 1'b1;
                end
                default: begin
                    r_state <= StWaitLock;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pll_stdy_rst_out = r_stdy_rst;
    assign sys_rst_out      = r_sys_rst;
    assign locked_out       = r_locked;
    assign lost_out         = r_lost;
    assign fault_out        = r_fault;
    assign retry_cnt_out    = r_retry;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with default parameters.
// Each scenario is a lock waveform. Expected outputs come from the
// arithmetic timeline of lock windows, retry pulses, release and fault edges.
// Edge numbering: edge 1 is the first rising edge after rst_in deasserts.
// "Rise r" means pll_lock_in is sampled high from edge r+1 onwards.

module tb_pll_reset_seq;

    localparam int LockWait = 16;
    localparam int Timeout  = 100;
    localparam int MaxRetry = 3;
    localparam int Pulse    = 4;
    localparam int Period   = Timeout + Pulse;
    localparam int Never    = 1 << 20;
`ifdef PLL_SEQ_RELOCK_EN
    localparam bit Relock = 1'b1;
`else
    localparam bit Relock = 1'b0;
`endif

    logic       clock_in;
    logic       rst_in;
    logic       pll_lock_in;
    logic       pll_stdy_rst_out;
    logic       sys_rst_out;
    logic       locked_out;
    logic       lost_out;
    logic       fault_out;
    logic [3:0] retry_cnt_out;

    pll_reset_seq #(
        .LOCK_WAIT_CYC(LockWait),
        .TIMEOUT_CYC  (Timeout),
        .MAX_RETRY    (MaxRetry),
        .RST_PULSE_CYC(Pulse)
    ) dut (
        .clock_in        (clock_in),
        .rst_in          (rst_in),
        .pll_lock_in     (pll_lock_in),
        .pll_stdy_rst_out(pll_stdy_rst_out),
        .sys_rst_out     (sys_rst_out),
        .locked_out      (locked_out),
        .lost_out        (lost_out),
        .fault_out       (fault_out),
        .retry_cnt_out   (retry_cnt_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Scenario description: rise, optional glitch (high h, low l), optional drop [d+1..u].
    int sc_r, sc_h, sc_l, sc_d, sc_u;
    // Derived timeline.
    int rel, n_ret, flt_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [8:0] obs_vec();
        return {sys_rst_out, pll_stdy_rst_out, locked_out, lost_out, fault_out, retry_cnt_out};
    endfunction

    function automatic logic lock_at(input int n);
        if (n <= sc_r) return 1'b0;
        if (sc_l > 0 && n > sc_r + sc_h && n <= sc_r + sc_h + sc_l) return 1'b0;
        if (sc_d >= 0 && n > sc_d && n <= sc_u) return 1'b0;
        return 1'b1;
    endfunction

    // Lock windows: window k opens at edge k*Period and times out at k*Period+Timeout.
    // Lock is first usable at edge r+3 (two synchronizer stages plus one decision).
    function automatic void plan();
        int w, e;
        bit found;
        rel   = -1;
        n_ret = 0;
        flt_e = -1;
        found = 1'b0;
        if (sc_l > 0) begin
            rel = sc_r + sc_h + sc_l + 3 + LockWait;
        end else begin
            for (int k = 0; k <= MaxRetry; k++) begin
                if (!found) begin
                    w = k * Period;
                    e = (sc_r + 3 > w + 1) ? sc_r + 3 : w + 1;
                    if (e <= w + Timeout) begin
                        rel   = e + LockWait;
                        n_ret = k;
                        found = 1'b1;
                    end
                end
            end
            if (!found) begin
                flt_e = MaxRetry * Period + Timeout;
                n_ret = MaxRetry;
            end
        end
    endfunction

    function automatic logic [8:0] exp_vec(input int n);
        logic run, lkd, lost, flt, stdy;
        logic [3:0] rc;
        run  = (rel >= 0) && (n >= rel);
        lost = (sc_d >= 0) && (n >= sc_d + 3);
        if (Relock && lost && n < sc_u + 3 + LockWait) run = 1'b0;
        lkd = run;
        if (!Relock && lost) lkd = lock_at(n - 2);
        flt  = (flt_e >= 0) && (n >= flt_e);
        stdy = 1'b0;
        rc   = 4'd0;
        for (int j = 0; j < n_ret; j++) begin
            if (n >= j * Period + Timeout) rc = rc + 4'd1;
            if (n >= j * Period + Timeout && n < j * Period + Period) stdy = 1'b1;
        end
        if (Relock && lost) rc = 4'd0;
        return {~run, stdy, lkd, lost, flt, rc};
    endfunction

    task automatic set_scn(input int r, input int h, input int l, input bit drop);
        sc_r = r;
        sc_h = h;
        sc_l = l;
        sc_d = -1;
        sc_u = -1;
        plan();
        if (drop && rel >= 0) begin
            sc_d = rel + 5 + int'($urandom_range(0, 20));
            sc_u = sc_d + 1 + int'($urandom_range(0, 40));
        end
    endtask

    function automatic int horizon();
        if (sc_d >= 0) return sc_u + 3 + LockWait + 30;
        if (rel >= 0) return rel + 30;
        return flt_e + 30;
    endfunction

    task automatic do_reset();
        rst_in      = 1'b1;
        pll_lock_in = 1'b0;
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        check_eq("reset_state", 32'(obs_vec()), 32'(9'b1_0000_0000));
    endtask

    task automatic run_scn(input string name, input int cycles);
        @(posedge clock_in);
        #1;
        rst_in      = 1'b0;
        pll_lock_in = lock_at(1);
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clock_in);
            #1;
            pll_lock_in = lock_at(n + 1);
            @(negedge clock_in);
            check_eq($sformatf("%s edge %0d", name, n), 32'(obs_vec()), 32'(exp_vec(n)));
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        pll_lock_in = 1'b0;

        // Clean lock: rise after edge 10, release at edge 29.
        do_reset();
        set_scn(10, 0, 0, 1'b0);
        run_scn("clean", horizon());

        // Never lock: three retry pulses, then fault.
        do_reset();
        set_scn(Never, 0, 0, 1'b0);
        run_scn("never", horizon());

        // Glitch: high 10 cycles, low 1, then high again.
        do_reset();
        set_scn(5, 10, 1, 1'b0);
        run_scn("glitch", horizon());

        // Lock loss while running, then restore.
        do_reset();
        set_scn(10, 0, 0, 1'b1);
        run_scn("loss", horizon());

        // Reset asserted in the 2nd cycle of the first retry pulse.
        do_reset();
        set_scn(Never, 0, 0, 1'b0);
        run_scn("pre_abort", Timeout + 1);
        rst_in = 1'b1;
        #1;
        check_eq("abort_stdy", 32'(pll_stdy_rst_out), 32'd0);
        check_eq("abort_retry", 32'(retry_cnt_out), 32'd0);
        check_eq("abort_sys_rst", 32'(sys_rst_out), 32'd1);
        do_reset();
        set_scn(10, 0, 0, 1'b0);
        run_scn("after_abort", horizon());

        // Randomized scenarios.
        for (int i = 0; i < 12; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            do_reset();
            case (kind)
                0: set_scn(int'($urandom_range(0, 450)), 0, 0, 1'b0);
                1: set_scn(int'($urandom_range(0, 30)), int'($urandom_range(1, 15)),
                           int'($urandom_range(1, 3)), 1'b0);
                2: set_scn(int'($urandom_range(0, 200)), 0, 0, 1'b1);
                default: set_scn(Never, 0, 0, 1'b0);
            endcase
            run_scn($sformatf("rand%0d_k%0d_r%0d", i, kind, sc_r), horizon());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
